// File: rtl/mem_arb_2p_if.sv
// Request/response bundle between the two requesters, the arbiter and the 1024x8 data memory.
// The slave modport is the arbiter's view; master is the view of whatever drives the requests and memory.
interface mem_arb_2p_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          i_p0_req;
  logic          i_p0_we;
  logic [AW-1:0] i_p0_addr;
  logic [DW-1:0] i_p0_wdata;
  logic          o_p0_gnt;
  logic          o_p0_rvalid;
  logic [DW-1:0] o_p0_rdata;

  logic          i_p1_req;
  logic          i_p1_we;
  logic [AW-1:0] i_p1_addr;
  logic [DW-1:0] i_p1_wdata;
  logic          o_p1_gnt;
  logic          o_p1_rvalid;
  logic [DW-1:0] o_p1_rdata;

  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_re;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    output o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re,
    input  i_mem_rdata
  );

  modport master (
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    input  o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_arb_2p.sv
// Two-port arbiter for the single-port data memory: CPU on port 0, UART loader on port 1.
// Round-robin with a run-length cap, read-data routing by tag, and a one-cycle read-after-write bubble.
module mem_arb_2p #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int MAXRUN = 4
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  mem_arb_2p_if.slave    bus
);
  localparam int RW = $clog2(MAXRUN + 1);

  typedef enum logic {IDLE, WHAZ} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] haz_addr_q, haz_addr_d;
  logic          rr_q, rr_d;
  logic          run_port_q, run_port_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;

  logic [1:0]    req, we, blocked, capped, elig, gnt, rvalid;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          gnt_any, gnt_port, wr_gnt;

  assign req      = {bus.i_p1_req, bus.i_p0_req};
  assign we       = {bus.i_p1_we, bus.i_p0_we};
  assign addr[0]  = bus.i_p0_addr;
  assign addr[1]  = bus.i_p1_addr;
  assign wdata[0] = bus.i_p0_wdata;
  assign wdata[1] = bus.i_p1_wdata;

  // A port is out of the running if it would read the address still retiring in memory,
  // or if it has had MAXRUN grants in a row while the other side waited.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign blocked[gi] = (state_q == WHAZ) && !we[gi] && (addr[gi] == haz_addr_q);
    assign capped[gi]  = (run_port_q == 1'(gi)) && (run_cnt_q == RW'(MAXRUN)) && req[1-gi];
    assign elig[gi]    = i_nrst && req[gi] && !blocked[gi] && !capped[gi];
    assign rvalid[gi]  = rd_pend_q && (rd_tag_q == 1'(gi));
  end

  always_comb begin
    gnt = '0;
    if (elig == 2'b11) begin
      gnt[rr_q] = 1'b1;
    end else begin
      gnt = elig;
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_port = gnt[1];
  assign wr_gnt   = gnt_any && we[gnt_port];

  assign bus.o_p0_gnt    = gnt[0];
  assign bus.o_p1_gnt    = gnt[1];
  assign bus.o_p0_rvalid = rvalid[0];
  assign bus.o_p1_rvalid = rvalid[1];
  assign bus.o_p0_rdata  = rvalid[0] ? bus.i_mem_rdata : '0;
  assign bus.o_p1_rdata  = rvalid[1] ? bus.i_mem_rdata : '0;

  assign bus.o_mem_addr  = gnt_any ? addr[gnt_port] : '0;
  assign bus.o_mem_wdata = gnt_any ? wdata[gnt_port] : '0;
  assign bus.o_mem_we    = wr_gnt;
  assign bus.o_mem_re    = gnt_any && !we[gnt_port];

  always_comb begin
    state_d    = IDLE;
    haz_addr_d = haz_addr_q;
    rr_d       = rr_q;
    run_port_d = run_port_q;
    run_cnt_d  = run_cnt_q;
    rd_pend_d  = gnt_any && !we[gnt_port];
    rd_tag_d   = rd_tag_q;

    if (rd_pend_d) begin
      rd_tag_d = gnt_port;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_gnt) begin
          state_d    = WHAZ;
          haz_addr_d = addr[gnt_port];
        end
      end
      WHAZ: begin
        if (wr_gnt) begin
          state_d    = WHAZ;
          haz_addr_d = addr[gnt_port];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Contention bookkeeping only moves on a real grant; a stalled read leaves it untouched.
    if (gnt_any) begin
      if (req[!gnt_port]) begin
        rr_d       = !gnt_port;
        run_port_d = gnt_port;
        if ((run_port_q == gnt_port) && (run_cnt_q != '0)) begin
          run_cnt_d = run_cnt_q + RW'(1);
        end else begin
          run_cnt_d = RW'(1);
        end
      end else begin
        run_cnt_d = '0;
      end
    end else if (!req[!run_port_q]) begin
      run_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      haz_addr_q <= '0;
      rr_q       <= 1'b0;
      run_port_q <= 1'b0;
      run_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      haz_addr_q <= haz_addr_d;
      rr_q       <= rr_d;
      run_port_q <= run_port_d;
      run_cnt_q  <= run_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end
endmodule

// File: tb/tb_mem_arb_2p.sv
// Bench for mem_arb_2p: directed scenarios plus random traffic against an ideal-memory scoreboard,
// with a memory model that retires writes one cycle late so a missing bubble shows up as stale data.
`timescale 1ns/1ps
module tb_mem_arb_2p;
  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int MAXRUN = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_2p_if #(.AW(AW), .DW(DW)) bus();

  mem_arb_2p #(.AW(AW), .DW(DW), .MAXRUN(MAXRUN)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  logic [1:0]    req_v = '0;
  logic [1:0]    we_v  = '0;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wd_v   [2];

  assign bus.i_p0_req   = req_v[0];
  assign bus.i_p0_we    = we_v[0];
  assign bus.i_p0_addr  = addr_v[0];
  assign bus.i_p0_wdata = wd_v[0];
  assign bus.i_p1_req   = req_v[1];
  assign bus.i_p1_we    = we_v[1];
  assign bus.i_p1_addr  = addr_v[1];
  assign bus.i_p1_wdata = wd_v[1];

  // Memory model: registered read, writes land one clock after their strobe.
  bit   [DW-1:0] mem_arr [1024];
  logic [DW-1:0] mem_rdata_r = '0;
  logic          wr_pend = 1'b0;
  logic [AW-1:0] wr_a = '0;
  logic [DW-1:0] wr_d = '0;
  logic          poke_v = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  always @(posedge clk) begin
    if (bus.o_mem_re) mem_rdata_r <= mem_arr[bus.o_mem_addr];
    if (wr_pend) mem_arr[wr_a] <= wr_d;
    if (poke_v) mem_arr[poke_a] <= poke_d;
    wr_pend <= bus.o_mem_we;
    wr_a    <= bus.o_mem_addr;
    wr_d    <= bus.o_mem_wdata;
  end
  assign bus.i_mem_rdata = mem_rdata_r;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: ideal memory (writes visible immediately) and the read response owed next cycle.
  bit   [DW-1:0] refm [1024];
  logic          pend_v = 1'b0;
  logic          pend_port = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic          last_wv = 1'b0;
  logic [AW-1:0] last_wa = '0;
  int            wait_c [2];
  logic [1:0]    m_g, m_blk;
  logic          m_gp;

  always @(negedge clk) begin
    m_g = {bus.o_p1_gnt, bus.o_p0_gnt};
    if (!nrst) begin
      chk("rst_outs", {m_g, bus.o_p0_rvalid, bus.o_p1_rvalid, bus.o_p0_rdata, bus.o_p1_rdata,
                       bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata, bus.o_mem_re}, 64'd0);
      pend_v    = 1'b0;
      last_wv   = 1'b0;
      wait_c[0] = 0;
      wait_c[1] = 0;
    end else begin
      chk("rvalid0", bus.o_p0_rvalid, pend_v && !pend_port);
      chk("rdata0", bus.o_p0_rdata, (pend_v && !pend_port) ? pend_data : '0);
      chk("rvalid1", bus.o_p1_rvalid, pend_v && pend_port);
      chk("rdata1", bus.o_p1_rdata, (pend_v && pend_port) ? pend_data : '0);
      for (int n = 0; n < 2; n++) begin
        m_blk[n] = last_wv && req_v[n] && !we_v[n] && (addr_v[n] == last_wa);
      end
      chk("gnt_onehot", &m_g, 0);
      chk("gnt_noreq", m_g & ~req_v, 0);
      chk("haz_read", m_g & m_blk, 0);
      chk("gnt_stall", (|req_v) && !(|m_g) && !(|m_blk), 0);
      m_gp = m_g[1];
      chk("mem_bus", {bus.o_mem_re, bus.o_mem_we, bus.o_mem_addr},
          (|m_g) ? {!we_v[m_gp], we_v[m_gp], addr_v[m_gp]} : 12'd0);
      if ((|m_g) && we_v[m_gp]) chk("mem_wdata", bus.o_mem_wdata, wd_v[m_gp]);

      pend_v = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (req_v[n] && !m_g[n]) wait_c[n]++;
      end
      if (|m_g) begin
        chk("wait_bound", wait_c[m_gp] > MAXRUN + 1, 0);
        wait_c[m_gp] = 0;
        if (we_v[m_gp]) begin
          refm[addr_v[m_gp]] = wd_v[m_gp];
          $display("txn cyc=%0d p%0d WR addr=%03h data=%02h", cyc, m_gp, addr_v[m_gp], wd_v[m_gp]);
        end else begin
          pend_v    = 1'b1;
          pend_port = m_gp;
          pend_data = refm[addr_v[m_gp]];
          $display("txn cyc=%0d p%0d RD addr=%03h expect=%02h", cyc, m_gp, addr_v[m_gp], pend_data);
        end
      end
      last_wv = (|m_g) && we_v[m_gp];
      last_wa = addr_v[m_gp];
      if (poke_v) refm[poke_a] = poke_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v[n]  = 1'b1;
    we_v[n]   = w;
    addr_v[n] = a;
    wd_v[n]   = d;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_a = a;
    poke_d = d;
    poke_v = 1'b1;
    tick();
    poke_v = 1'b0;
  endtask

  task automatic rand_req(input int n);
    logic [AW-1:0] a;
    case ($urandom_range(0, 4))
      0:       a = 10'h010;
      1:       a = 10'h011;
      2:       a = 10'h3FF;
      3:       a = 10'h000;
      default: a = AW'($urandom_range(0, 1023));
    endcase
    set_req(n, $urandom_range(0, 2) == 0, a, DW'($urandom));
  endtask

  initial begin
    logic       g0s, g1s, prev, done;
    logic [1:0] gs;
    int         waited;
    addr_v[0] = '0; addr_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;

    #1 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // p0 lone read
    poke(10'h155, 8'hA5);
    set_req(0, 1'b0, 10'h155, '0);
    @(negedge clk); chk("t2_gnt0", bus.o_p0_gnt, 1);
    tick(); req_v[0] = 1'b0;
    @(negedge clk);
    chk("t2_rv0", bus.o_p0_rvalid, 1);
    chk("t2_rd0", bus.o_p0_rdata, 8'hA5);
    chk("t2_rv1", bus.o_p1_rvalid, 0);

    // write then immediate read of the same address from the other port
    tick(); set_req(0, 1'b1, 10'h010, 8'h3C);
    @(negedge clk); chk("t3_wgnt", bus.o_p0_gnt, 1);
    tick(); req_v[0] = 1'b0; set_req(1, 1'b0, 10'h010, '0);
    @(negedge clk); chk("t3_stall", bus.o_p1_gnt, 0);
    tick();
    @(negedge clk); chk("t3_gnt", bus.o_p1_gnt, 1);
    tick(); req_v[1] = 1'b0;
    @(negedge clk);
    chk("t3_rv1", bus.o_p1_rvalid, 1);
    chk("t3_rd1", bus.o_p1_rdata, 8'h3C);

    // both ports streaming reads
    tick(); tick();
    set_req(0, 1'b0, AW'($urandom_range(0, 1023)), '0);
    set_req(1, 1'b0, AW'($urandom_range(0, 1023)), '0);
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      g0s = bus.o_p0_gnt; g1s = bus.o_p1_gnt;
      chk("t4_one", g0s ^ g1s, 1);
      if (i > 0) chk("t4_alt", g1s, !prev);
      prev = g1s;
      tick();
      if (g0s) addr_v[0] = AW'($urandom_range(0, 1023));
      if (g1s) addr_v[1] = AW'($urandom_range(0, 1023));
    end
    req_v = '0;

    // p1 streaming, p0 asks once
    tick();
    set_req(1, 1'b0, AW'($urandom_range(0, 1023)), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); g1s = bus.o_p1_gnt;
      tick();
      if (g1s) addr_v[1] = AW'($urandom_range(0, 1023));
    end
    set_req(0, 1'b0, AW'($urandom_range(0, 1023)), '0);
    waited = 0; done = 1'b0;
    for (int i = 0; i < MAXRUN + 4 && !done; i++) begin
      @(negedge clk);
      waited++;
      done = bus.o_p0_gnt;
      g1s  = bus.o_p1_gnt;
      tick();
      if (done) req_v[0] = 1'b0;
      if (g1s) addr_v[1] = AW'($urandom_range(0, 1023));
    end
    chk("t5_p0_lat", done && (waited <= MAXRUN), 1);
    req_v = '0;

    // back-to-back writes, then a read of the second address
    tick();
    set_req(0, 1'b1, 10'h3FF, 8'h81);
    @(negedge clk); chk("t6_w1", bus.o_p0_gnt, 1);
    tick(); set_req(0, 1'b1, 10'h000, 8'h7E);
    @(negedge clk); chk("t6_w2", bus.o_p0_gnt, 1);
    tick(); set_req(0, 1'b0, 10'h000, '0);
    @(negedge clk); chk("t6_bubble", bus.o_p0_gnt, 0);
    tick();
    @(negedge clk); chk("t6_rgnt", bus.o_p0_gnt, 1);
    tick(); req_v[0] = 1'b0;
    @(negedge clk);
    chk("t6_rv", bus.o_p0_rvalid, 1);
    chk("t6_rd", bus.o_p0_rdata, 8'h7E);

    // random traffic concentrated on a few addresses to provoke hazards
    tick();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      gs = {bus.o_p1_gnt, bus.o_p0_gnt};
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!req_v[n] || gs[n]) begin
          if ($urandom_range(0, 3) != 0) rand_req(n);
          else req_v[n] = 1'b0;
        end
      end
    end
    req_v = '0;
    tick(); tick();

    // reset asserted while a read is in flight
    set_req(0, 1'b0, 10'h155, '0);
    set_req(1, 1'b0, 10'h3FF, '0);
    @(negedge clk); chk("t1_pre_gnt", bus.o_p0_gnt | bus.o_p1_gnt, 1);
    #2 nrst = 1'b0;
    #1 chk("t1_async", {bus.o_p0_gnt, bus.o_p1_gnt, bus.o_mem_re, bus.o_mem_addr}, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("t1_rv0", bus.o_p0_rvalid, 0);
    chk("t1_rv1", bus.o_p1_rvalid, 0);
    chk("t1_first", {bus.o_p1_gnt, bus.o_p0_gnt}, 2'b01);
    tick(); req_v = '0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
